// File: rtl/mem_access_if.sv
// Request/response handshake between the MEM stage
// and the load/store sequencer.
interface mem_access_if #(
  parameter int AW = 10
);
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [1:0]    req_size;
  logic          req_signed;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic          resp_err;
  logic [31:0]   resp_rdata;

  modport master (
    output req_valid, req_write, req_size,
    output req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_err,
    input  resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_size,
    input  req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_err,
    output resp_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store sequencer: byte/half/word accesses with
// read-modify-write for sub-word stores.
module mem_access_unit #(
  parameter int AW    = 10,
  parameter int DEPTH = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_access_if.slave   bus,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_din,
  output logic          mem_wr,
  input  logic [31:0]   mem_dout
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RMW_RD,
    RMW_WR
  } state_t;

  state_t state, nxt;

  logic          r_write;
  logic [1:0]    r_size;
  logic          r_signed;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   mbuf;

  logic          acc;
  logic          bad;
  logic          mis;
  logic          oor;
  logic [AW-1:0] a_al;
  logic [4:0]    sh;
  logic [31:0]   rd_sh;
  logic [31:0]   ld;
  logic [31:0]   mask;
  logic [31:0]   merged;

  assign bus.req_ready = (state == IDLE);
  assign acc = bus.req_valid & bus.req_ready;

  // Request legality: reserved size, alignment, range.
  assign a_al = {bus.req_addr[AW-1:2], 2'b00};
  assign oor  = a_al > AW'(DEPTH - 4);
  assign mis  =
    ((bus.req_size == 2'b01) & bus.req_addr[0]) |
    ((bus.req_size == 2'b10) &
     (|bus.req_addr[1:0]));
  assign bad  = (bus.req_size == 2'b11) | mis | oor;

  assign mem_addr = {r_addr[AW-1:2], 2'b00};

  // Lane shift; halves are 2-aligned so one rule fits.
  assign sh    = {r_addr[1:0], 3'b000};
  assign rd_sh = mem_dout >> sh;

  // Load lane select and extension.
  always_comb begin
    ld = rd_sh;
    unique case (1'b1)
      r_size == 2'b00:
        ld = {{24{r_signed & rd_sh[7]}},
              rd_sh[7:0]};
      r_size == 2'b01:
        ld = {{16{r_signed & rd_sh[15]}},
              rd_sh[15:0]};
      default:
        ld = rd_sh;
    endcase
  end

  // Merge store lane into the buffered word.
  always_comb begin
    mask = 32'h0000_00ff << sh;
    if (r_size == 2'b01)
      mask = 32'h0000_ffff << sh;
    merged = (mbuf & ~mask) |
             ((r_wdata << sh) & mask);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // Next state and Moore memory-write outputs.
  always_comb begin
    nxt     = state;
    mem_wr  = 1'b0;
    mem_din = 32'h0;
    unique case (state)
      IDLE: begin
        if (acc && !bad) begin
          if (bus.req_write &&
              bus.req_size != 2'b10)
            nxt = RMW_RD;
          else
            nxt = ACCESS;
        end
      end
      ACCESS: begin
        nxt = IDLE;
        if (r_write) begin
          mem_wr  = 1'b1;
          mem_din = r_wdata;
        end
      end
      RMW_RD: nxt = RMW_WR;
      RMW_WR: begin
        nxt     = IDLE;
        mem_wr  = 1'b1;
        mem_din = merged;
      end
      default: nxt = IDLE;
    endcase
  end

  // Capture legal requests and the RMW read word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write  <= 1'b0;
      r_size   <= 2'b00;
      r_signed <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= 32'h0;
      mbuf     <= 32'h0;
    end else begin
      if (acc && !bad) begin
        r_write  <= bus.req_write;
        r_size   <= bus.req_size;
        r_signed <= bus.req_signed;
        r_addr   <= bus.req_addr;
        r_wdata  <= bus.req_wdata;
      end
      if (state == RMW_RD)
        mbuf <= mem_dout;
    end
  end

  // One-cycle response pulse; rdata held between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.resp_valid <= 1'b0;
      bus.resp_err   <= 1'b0;
      bus.resp_rdata <= 32'h0;
    end else begin
      bus.resp_valid <= 1'b0;
      if (acc && bad) begin
        bus.resp_valid <= 1'b1;
        bus.resp_err   <= 1'b1;
        bus.resp_rdata <= 32'h0;
      end else if (state == ACCESS) begin
        bus.resp_valid <= 1'b1;
        bus.resp_err   <= 1'b0;
        bus.resp_rdata <= r_write ? 32'h0 : ld;
      end else if (state == RMW_WR) begin
        bus.resp_valid <= 1'b1;
        bus.resp_err   <= 1'b0;
        bus.resp_rdata <= 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a
// falling-edge-write memory model.
module tb_mem_access_unit;

  localparam int AW = 10;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_din;
  logic          mem_wr;
  logic [31:0]   mem_dout;

  mem_access_if #(.AW(AW)) bus ();

  mem_access_unit #(.AW(AW), .DEPTH(64)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_wr   (mem_wr),
    .mem_dout (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [16];
  int          wr_cnt;
  logic [31:0] last_wa;
  logic [31:0] last_wd;

  assign mem_dout = mem[mem_addr[5:2]];

  always @(negedge clk) begin
    if (mem_wr) begin
      mem[mem_addr[5:2]] <= mem_din;
      wr_cnt  <= wr_cnt + 1;
      last_wa <= 32'(mem_addr);
      last_wd <= mem_din;
    end
  end

  int checks;
  int errors;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        sg;
    logic [9:0]  addr;
    logic [31:0] wd;
    logic        err;
    logic [31:0] rd;
    int          lat;
    int          nwr;
    logic [31:0] wa;
    logic [31:0] wdin;
  } vec_t;

  vec_t vt [$];

  function automatic vec_t mk(
    input logic w, input logic [1:0] sz,
    input logic sg, input logic [9:0] a,
    input logic [31:0] wd, input logic e,
    input logic [31:0] rd, input int lat,
    input int nwr, input logic [31:0] wa,
    input logic [31:0] wdin);
    vec_t v;
    v.w = w; v.sz = sz; v.sg = sg;
    v.addr = a; v.wd = wd; v.err = e;
    v.rd = rd; v.lat = lat; v.nwr = nwr;
    v.wa = wa; v.wdin = wdin;
    return v;
  endfunction

  task automatic run(input vec_t v,
                     output bit got,
                     output int lat,
                     output logic e,
                     output logic [31:0] rd);
    int n;
    @(negedge clk);
    bus.req_write  = v.w;
    bus.req_size   = v.sz;
    bus.req_signed = v.sg;
    bus.req_addr   = v.addr;
    bus.req_wdata  = v.wd;
    bus.req_valid  = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    got = 0; lat = 0; e = 1'bx; rd = 'x;
    for (int k = 1; k <= 6 && !got; k++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        got = 1;
        lat = k;
        e   = bus.resp_err;
        rd  = bus.resp_rdata;
      end
    end
  endtask

  initial begin
    bit          got;
    int          lat;
    logic        e;
    logic [31:0] rd;
    int          w0;
    string       t;

    checks = 0;
    errors = 0;
    wr_cnt = 0;
    last_wa = 0;
    last_wd = 0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = 32'h0;

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 1);
    chk("rst_rvalid", 32'(bus.resp_valid), 0);
    chk("rst_rdata", bus.resp_rdata, 0);
    chk("rst_memwr", 32'(mem_wr), 0);
    chk("rst_maddr", 32'(mem_addr), 0);
    chk("rst_mdin", mem_din, 0);
    rst_n = 1'b1;

    vt.push_back(mk(1,2,0,8, 32'h89ABCDEF,
      0,0,2,1,8,32'h89ABCDEF));
    vt.push_back(mk(0,0,1,9, 0,
      0,32'hFFFFFFCD,2,0,0,0));
    vt.push_back(mk(0,0,0,9, 0,
      0,32'h000000CD,2,0,0,0));
    vt.push_back(mk(0,1,1,10,0,
      0,32'hFFFF89AB,2,0,0,0));
    vt.push_back(mk(1,2,0,12,32'h01234567,
      0,0,2,1,12,32'h01234567));
    vt.push_back(mk(1,0,0,13,32'hFFFFFF5A,
      0,0,3,1,12,32'h01235A67));
    vt.push_back(mk(0,2,0,12,0,
      0,32'h01235A67,2,0,0,0));
    vt.push_back(mk(0,1,0,14,0,
      0,32'h00000123,2,0,0,0));
    vt.push_back(mk(0,1,0,5, 0,
      1,0,1,0,0,0));
    vt.push_back(mk(1,2,0,6, 32'hDEADBEEF,
      1,0,1,0,0,0));
    vt.push_back(mk(0,2,0,64,0,
      1,0,1,0,0,0));
    vt.push_back(mk(0,3,0,4, 0,
      1,0,1,0,0,0));
    vt.push_back(mk(1,2,0,60,32'hCAFEF00D,
      0,0,2,1,60,32'hCAFEF00D));
    vt.push_back(mk(0,2,0,60,0,
      0,32'hCAFEF00D,2,0,0,0));
    vt.push_back(mk(1,1,0,16,32'h1234BEEF,
      0,0,3,1,16,32'h0000BEEF));
    vt.push_back(mk(0,1,1,16,0,
      0,32'hFFFFBEEF,2,0,0,0));
    vt.push_back(mk(1,0,0,63,32'h00000080,
      0,0,3,1,60,32'h80FEF00D));
    vt.push_back(mk(0,0,1,63,0,
      0,32'hFFFFFF80,2,0,0,0));
    vt.push_back(mk(1,1,0,18,32'h0000A5A5,
      0,0,3,1,16,32'hA5A5BEEF));
    vt.push_back(mk(0,2,0,16,0,
      0,32'hA5A5BEEF,2,0,0,0));
    vt.push_back(mk(1,2,0,4, 32'h01234567,
      0,0,2,1,4,32'h01234567));
    vt.push_back(mk(1,2,0,8, 32'h01234567,
      0,0,2,1,8,32'h01234567));

    foreach (vt[i]) begin
      w0 = wr_cnt;
      run(vt[i], got, lat, e, rd);
      t = $sformatf("v%0d", i);
      chk({t,"_got"}, 32'(got), 1);
      chk({t,"_err"}, 32'(e), 32'(vt[i].err));
      chk({t,"_rdata"}, rd, vt[i].rd);
      chk({t,"_lat"}, lat, vt[i].lat);
      chk({t,"_nwr"}, wr_cnt - w0, vt[i].nwr);
      if (vt[i].nwr != 0) begin
        chk({t,"_waddr"}, last_wa, vt[i].wa);
        chk({t,"_wdin"}, last_wd, vt[i].wdin);
      end
    end

    // Back-to-back word loads with req_valid held.
    @(negedge clk);
    bus.req_write = 1'b0;
    bus.req_size  = 2'b10;
    bus.req_addr  = 10'd4;
    bus.req_valid = 1'b1;
    chk("b2b_ready0", 32'(bus.req_ready), 1);
    @(negedge clk);
    chk("b2b_busy", 32'(bus.req_ready), 0);
    bus.req_addr = 10'd8;
    @(negedge clk);
    chk("b2b_v1", 32'(bus.resp_valid), 1);
    chk("b2b_d1", bus.resp_rdata, 32'h01234567);
    chk("b2b_ready1", 32'(bus.req_ready), 1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("b2b_busy2", 32'(bus.req_ready), 0);
    chk("b2b_pulse", 32'(bus.resp_valid), 0);
    @(negedge clk);
    chk("b2b_v2", 32'(bus.resp_valid), 1);
    chk("b2b_d2", bus.resp_rdata, 32'h01234567);

    // Reset in the first half of RMW_WR.
    @(negedge clk);
    w0 = wr_cnt;
    bus.req_write  = 1'b1;
    bus.req_size   = 2'b01;
    bus.req_addr   = 10'd16;
    bus.req_wdata  = 32'h00001111;
    bus.req_valid  = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("rmw_wr_hi", 32'(mem_wr), 1);
    rst_n = 1'b0;
    #1;
    chk("rmw_wr_drop", 32'(mem_wr), 0);
    @(negedge clk);
    #1;
    chk("rmw_nowrite", wr_cnt - w0, 0);
    chk("rmw_mem", mem[4], 32'hA5A5BEEF);
    @(negedge clk);
    rst_n = 1'b1;
    w0 = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bus.resp_valid) w0++;
    end
    chk("rst_noresp", w0, 0);
    chk("rst2_ready", 32'(bus.req_ready), 1);
    chk("rst2_rdata", bus.resp_rdata, 0);
    chk("rst2_maddr", 32'(mem_addr), 0);
    chk("rst2_mdin", mem_din, 0);
    chk("rst2_memwr", 32'(mem_wr), 0);

    run(mk(0,2,0,16,0,0,0,0,0,0,0),
        got, lat, e, rd);
    chk("post_got", 32'(got), 1);
    chk("post_rdata", rd, 32'hA5A5BEEF);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
